// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the per-lane pipeline buses around the memory stage.
//   ex_*  : ex->mem pipeline register contents (driven by master, read by mem stage)
//   pf_*  : combinational forwarding from the mem stage to dispatch
//   wb_*  : registered mem->wb pipeline register contents
// Lane 0 is the older instruction in every array.
interface mem_stage_if #(
  parameter int unsigned ISSUE_WIDTH = 2
);
  // ex -> mem
  logic [ISSUE_WIDTH-1:0]       ex_valid;
  logic [ISSUE_WIDTH-1:0][31:0] ex_pc;
  logic [ISSUE_WIDTH-1:0]       ex_reg_write_en;
  logic [ISSUE_WIDTH-1:0][4:0]  ex_reg_write_addr;
  logic [ISSUE_WIDTH-1:0][31:0] ex_reg_write_data;
  logic [ISSUE_WIDTH-1:0]       ex_is_load;
  logic [ISSUE_WIDTH-1:0][2:0]  ex_load_type;
  logic [ISSUE_WIDTH-1:0][1:0]  ex_addr_low;

  // mem -> dispatch forwarding
  logic [ISSUE_WIDTH-1:0]       pf_reg_write_en;
  logic [ISSUE_WIDTH-1:0][4:0]  pf_reg_write_addr;
  logic [ISSUE_WIDTH-1:0][31:0] pf_reg_write_data;

  // mem -> wb
  logic [ISSUE_WIDTH-1:0]       wb_valid;
  logic [ISSUE_WIDTH-1:0][31:0] wb_pc;
  logic [ISSUE_WIDTH-1:0]       wb_reg_write_en;
  logic [ISSUE_WIDTH-1:0][4:0]  wb_reg_write_addr;
  logic [ISSUE_WIDTH-1:0][31:0] wb_reg_write_data;

  // Upstream / environment side
  modport master (
    output ex_valid, ex_pc, ex_reg_write_en, ex_reg_write_addr, ex_reg_write_data,
    output ex_is_load, ex_load_type, ex_addr_low,
    input  pf_reg_write_en, pf_reg_write_addr, pf_reg_write_data,
    input  wb_valid, wb_pc, wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data
  );

  // Memory stage side
  modport slave (
    input  ex_valid, ex_pc, ex_reg_write_en, ex_reg_write_addr, ex_reg_write_data,
    input  ex_is_load, ex_load_type, ex_addr_low,
    output pf_reg_write_en, pf_reg_write_addr, pf_reg_write_data,
    output wb_valid, wb_pc, wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: two-lane memory stage. Aligns and extends dcache load data, stalls the
// pipeline while a load waits for data_ok, forwards results to dispatch and registers
// them into the mem->wb pipeline register.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_flush         discard stage contents
//   i_pause         writeback stall; holds the mem->wb register
//   io_mem          ex->mem inputs, forwarding and mem->wb outputs (mem_stage_if.slave)
//   i_data_ok       dcache load data valid pulse
//   i_rdata         dcache load word
//   o_pause_mem     stall request to ctrl/execute
//   o_load_busy     a lane holds a load whose data is not yet available
//   o_stall_cnt     saturating count of cycles with o_pause_mem high
module mem_stage #(
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_pause,
  mem_stage_if.slave       io_mem,
  input  logic             i_data_ok,
  input  logic [31:0]      i_rdata,
  output logic             o_pause_mem,
  output logic             o_load_busy,
  output logic [31:0]      o_stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_e;

  state_e r_state, w_state_nxt;
  logic   w_buf_capture;
  logic [31:0] r_buf;

  logic [ISSUE_WIDTH-1:0]       r_wb_valid;
  logic [ISSUE_WIDTH-1:0][31:0] r_wb_pc;
  logic [ISSUE_WIDTH-1:0]       r_wb_reg_write_en;
  logic [ISSUE_WIDTH-1:0][4:0]  r_wb_reg_write_addr;
  logic [ISSUE_WIDTH-1:0][31:0] r_wb_reg_write_data;
  logic [31:0]                  r_stall_cnt;

  logic [ISSUE_WIDTH-1:0]       w_ld_lane;
  logic                         w_load_present;
  logic                         w_ld_sel;
  logic [31:0]                  w_ext;
  logic [31:0]                  w_ld_value;
  logic [ISSUE_WIDTH-1:0][31:0] w_res_data;
  logic                         w_drain;

  // Byte/halfword select and sign/zero extension of a dcache word.
  function automatic logic [31:0] load_extend(input logic [2:0]  lt,
                                              input logic [1:0]  al,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (al)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = al[1] ? rd[31:16] : rd[15:0];
    case (lt)
      3'd0:    load_extend = {{24{b[7]}}, b};
      3'd1:    load_extend = {{16{h[15]}}, h};
      3'd4:    load_extend = {24'h0, b};
      3'd5:    load_extend = {16'h0, h};
      default: load_extend = rd;
    endcase
  endfunction

  assign w_ld_lane      = io_mem.ex_valid & io_mem.ex_is_load;
  assign w_load_present = |w_ld_lane;
  // At most one lane carries a load; prefer lane 0 when it does.
  assign w_ld_sel       = ~w_ld_lane[0];
  assign w_ext          = load_extend(io_mem.ex_load_type[w_ld_sel],
                                      io_mem.ex_addr_low[w_ld_sel], i_rdata);
  // In HOLD the dcache pulse is long gone; the captured value is authoritative.
  assign w_ld_value     = (r_state == HOLD) ? r_buf : w_ext;
  assign w_drain        = (r_state == DRAIN);

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_res_data[i] = w_ld_lane[i] ? w_ld_value : io_mem.ex_reg_write_data[i];
    end
  end

  assign o_pause_mem = (w_load_present && (r_state == IDLE || r_state == WAIT) && !i_data_ok)
                       || w_drain;
  assign o_load_busy = o_pause_mem && !w_drain;

  // Forwarding: only the lane actually waiting on load data is suppressed, so an older
  // ALU result in the other lane still reaches dispatch.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      io_mem.pf_reg_write_en[i]   = 1'b0;
      io_mem.pf_reg_write_addr[i] = 5'd0;
      io_mem.pf_reg_write_data[i] = 32'd0;
      if (!w_drain) begin
        io_mem.pf_reg_write_en[i]   = io_mem.ex_valid[i] && io_mem.ex_reg_write_en[i]
                                      && !(w_ld_lane[i] && o_load_busy);
        io_mem.pf_reg_write_addr[i] = io_mem.ex_reg_write_addr[i];
        io_mem.pf_reg_write_data[i] = w_res_data[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_load_present && !i_data_ok) begin
          w_state_nxt = WAIT;
        end else if (w_load_present && i_data_ok && i_pause) begin
          w_state_nxt   = HOLD;
          w_buf_capture = 1'b1;
        end
      end
      WAIT: begin
        if (i_flush) begin
          // Without data_ok the dcache reply is still in flight and must be swallowed.
          w_state_nxt = i_data_ok ? IDLE : DRAIN;
        end else if (i_data_ok) begin
          if (i_pause) begin
            w_state_nxt   = HOLD;
            w_buf_capture = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (i_flush || !i_pause) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (i_data_ok) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_buf_capture) begin
        r_buf <= w_ext;
      end
    end
  end

  // mem->wb register; both lanes always commit together.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wb_valid          <= '0;
      r_wb_pc             <= '0;
      r_wb_reg_write_en   <= '0;
      r_wb_reg_write_addr <= '0;
      r_wb_reg_write_data <= '0;
    end else if (!i_pause) begin
      if (o_pause_mem) begin
        r_wb_valid          <= '0;
        r_wb_pc             <= '0;
        r_wb_reg_write_en   <= '0;
        r_wb_reg_write_addr <= '0;
        r_wb_reg_write_data <= '0;
      end else begin
        r_wb_valid          <= io_mem.ex_valid;
        r_wb_pc             <= io_mem.ex_pc;
        r_wb_reg_write_en   <= io_mem.ex_reg_write_en;
        r_wb_reg_write_addr <= io_mem.ex_reg_write_addr;
        r_wb_reg_write_data <= w_res_data;
      end
    end
  end

  // Stall counter ignores flush so that it reflects total lost cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (o_pause_mem && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign io_mem.wb_valid          = r_wb_valid;
  assign io_mem.wb_pc             = r_wb_pc;
  assign io_mem.wb_reg_write_en   = r_wb_reg_write_en;
  assign io_mem.wb_reg_write_addr = r_wb_reg_write_addr;
  assign io_mem.wb_reg_write_data = r_wb_reg_write_data;
  assign o_stall_cnt              = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. A table of single-cycle load/ALU vectors
// followed by hand-written multi-cycle sequences for stalls, HOLD, DRAIN and reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, flush, pause, data_ok;
  logic [31:0] rdata;
  logic        pause_mem, load_busy;
  logic [31:0] stall_cnt;

  mem_stage_if #(.ISSUE_WIDTH(2)) bus ();

  mem_stage #(.ISSUE_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_pause     (pause),
    .io_mem      (bus),
    .i_data_ok   (data_ok),
    .i_rdata     (rdata),
    .o_pause_mem (pause_mem),
    .o_load_busy (load_busy),
    .o_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_stall;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  is_load;
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        dok;
    logic [31:0] rd;
    logic        exp_pm;
    logic [1:0]  exp_pf_en;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Lane 0 writes r5, lane 1 writes r6; reg_write_en follows valid.
  task automatic drive(input logic [1:0] v, input logic [1:0] ld, input logic [2:0] lt,
                       input logic [1:0] al, input logic [31:0] d0, input logic [31:0] d1);
    bus.ex_valid             = v;
    bus.ex_reg_write_en      = v;
    bus.ex_pc[0]             = 32'h0000_1000;
    bus.ex_pc[1]             = 32'h0000_1004;
    bus.ex_reg_write_addr[0] = 5'd5;
    bus.ex_reg_write_addr[1] = 5'd6;
    bus.ex_reg_write_data[0] = d0;
    bus.ex_reg_write_data[1] = d1;
    bus.ex_is_load           = ld;
    bus.ex_load_type[0]      = lt;
    bus.ex_load_type[1]      = lt;
    bus.ex_addr_low[0]       = al;
    bus.ex_addr_low[1]       = al;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 2'b01, 3'd0, 2'd3, 32'h0,    32'h0,    1'b1, 32'h8000_0000,
                 1'b0, 2'b01, 32'hFFFF_FF80, 32'h0};
    vecs[1]  = '{2'b11, 2'b00, 3'd0, 2'd0, 32'h7,    32'h1234, 1'b0, 32'h0,
                 1'b0, 2'b11, 32'h7, 32'h1234};
    vecs[2]  = '{2'b11, 2'b10, 3'd4, 2'd1, 32'hAAAA, 32'hFFFF, 1'b1, 32'h0000_F100,
                 1'b0, 2'b11, 32'hAAAA, 32'h0000_00F1};
    vecs[3]  = '{2'b01, 2'b01, 3'd1, 2'd2, 32'h0,    32'h0,    1'b1, 32'h8001_7FFF,
                 1'b0, 2'b01, 32'hFFFF_8001, 32'h0};
    vecs[4]  = '{2'b01, 2'b01, 3'd1, 2'd1, 32'h0,    32'h0,    1'b1, 32'h1234_8765,
                 1'b0, 2'b01, 32'hFFFF_8765, 32'h0};
    vecs[5]  = '{2'b01, 2'b01, 3'd5, 2'd0, 32'h0,    32'h0,    1'b1, 32'h0000_F00D,
                 1'b0, 2'b01, 32'h0000_F00D, 32'h0};
    vecs[6]  = '{2'b11, 2'b10, 3'd2, 2'd0, 32'h11,   32'h0,    1'b1, 32'hDEAD_BEEF,
                 1'b0, 2'b11, 32'h11, 32'hDEAD_BEEF};
    vecs[7]  = '{2'b01, 2'b01, 3'd3, 2'd0, 32'h0,    32'h0,    1'b1, 32'h1357_9BDF,
                 1'b0, 2'b01, 32'h1357_9BDF, 32'h0};
    vecs[8]  = '{2'b01, 2'b01, 3'd0, 2'd1, 32'h0,    32'h0,    1'b1, 32'h0000_7F00,
                 1'b0, 2'b01, 32'h0000_007F, 32'h0};
    vecs[9]  = '{2'b11, 2'b00, 3'd0, 2'd0, 32'h99,   32'h77,   1'b1, 32'hFFFF_FFFF,
                 1'b0, 2'b11, 32'h99, 32'h77};
    vecs[10] = '{2'b10, 2'b10, 3'd4, 2'd2, 32'h0,    32'h0,    1'b1, 32'h00AB_0000,
                 1'b0, 2'b10, 32'h0, 32'h0000_00AB};
    vecs[11] = '{2'b01, 2'b01, 3'd7, 2'd3, 32'h0,    32'h0,    1'b1, 32'hCAFE_0001,
                 1'b0, 2'b01, 32'hCAFE_0001, 32'h0};
    vecs[12] = '{2'b01, 2'b01, 3'd5, 2'd3, 32'h0,    32'h0,    1'b1, 32'h9876_0000,
                 1'b0, 2'b01, 32'h0000_9876, 32'h0};

    // Reset
    rst = 1'b1; flush = 1'b0; pause = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    drive(2'b00, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0);
    exp_stall = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wb_valid", {30'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_data0", bus.wb_reg_write_data[0], 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_pause_mem", {31'd0, pause_mem}, 32'd0);
    check("rst_load_busy", {31'd0, load_busy}, 32'd0);
    check("rst_pf_en", {30'd0, bus.pf_reg_write_en}, 32'd0);

    // Single-cycle vectors: all complete in the arrival cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].is_load, vecs[i].lt, vecs[i].al, vecs[i].d0, vecs[i].d1);
      data_ok = vecs[i].dok;
      rdata   = vecs[i].rd;
      #1;
      check($sformatf("v%0d_pause_mem", i), {31'd0, pause_mem}, {31'd0, vecs[i].exp_pm});
      check($sformatf("v%0d_pf_en", i), {30'd0, bus.pf_reg_write_en}, {30'd0, vecs[i].exp_pf_en});
      check($sformatf("v%0d_pf_data0", i), bus.pf_reg_write_data[0], vecs[i].exp0);
      check($sformatf("v%0d_pf_data1", i), bus.pf_reg_write_data[1], vecs[i].exp1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wb_valid", i), {30'd0, bus.wb_valid}, {30'd0, vecs[i].valid});
      check($sformatf("v%0d_wb_data0", i), bus.wb_reg_write_data[0], vecs[i].exp0);
      check($sformatf("v%0d_wb_data1", i), bus.wb_reg_write_data[1], vecs[i].exp1);
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0);
    data_ok = 1'b0;
    #1;
    check("table_stall_cnt", stall_cnt, exp_stall);

    // Lane 1 LHU, data_ok three cycles late
    drive(2'b10, 2'b10, 3'd5, 2'd2, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("late%0d_pause_mem", c), {31'd0, pause_mem}, 32'd1);
      check($sformatf("late%0d_load_busy", c), {31'd0, load_busy}, 32'd1);
      check($sformatf("late%0d_pf_en", c), {30'd0, bus.pf_reg_write_en}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("late%0d_bubble", c), {30'd0, bus.wb_valid}, 32'd0);
      exp_stall = exp_stall + 32'd1;
    end
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hBEEF_1234;
    #1;
    check("late_dok_pause_mem", {31'd0, pause_mem}, 32'd0);
    check("late_dok_pf_data1", bus.pf_reg_write_data[1], 32'h0000_BEEF);
    @(posedge clk);
    #1;
    check("late_wb_data1", bus.wb_reg_write_data[1], 32'h0000_BEEF);
    check("late_wb_valid", {30'd0, bus.wb_valid}, 32'd2);
    check("late_stall_cnt", stall_cnt, exp_stall);
    check("late_stall_cnt_abs", stall_cnt, 32'd3);

    // Data arrives while writeback is paused: HOLD supplies the buffered value
    @(negedge clk);
    data_ok = 1'b0; rdata = 32'h0;
    drive(2'b01, 2'b01, 3'd2, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hCAFE_F00D; pause = 1'b1;
    #1;
    check("hold_dok_pause_mem", {31'd0, pause_mem}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0; rdata = 32'h1111_2222;
    #1;
    check("hold_pause_mem", {31'd0, pause_mem}, 32'd0);
    check("hold_pf_en", {30'd0, bus.pf_reg_write_en}, 32'd1);
    check("hold_pf_data0", bus.pf_reg_write_data[0], 32'hCAFE_F00D);
    check("hold_wb_valid", {30'd0, bus.wb_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    pause = 1'b0;
    #1;
    check("hold_release_pause_mem", {31'd0, pause_mem}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_wb_data0", bus.wb_reg_write_data[0], 32'hCAFE_F00D);
    check("hold_wb_valid_after", {30'd0, bus.wb_valid}, 32'd1);
    check("hold_stall_cnt", stall_cnt, exp_stall);

    // Flush while waiting: DRAIN swallows the orphaned data_ok
    @(negedge clk);
    drive(2'b01, 2'b01, 3'd2, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_pause_mem", {31'd0, pause_mem}, 32'd1);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    #1;
    check("flush_wb_valid", {30'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(2'b01, 2'b00, 3'd0, 2'd0, 32'h55, 32'h0);
    #1;
    check("drain_pause_mem", {31'd0, pause_mem}, 32'd1);
    check("drain_load_busy", {31'd0, load_busy}, 32'd0);
    check("drain_pf_en", {30'd0, bus.pf_reg_write_en}, 32'd0);
    check("drain_pf_data0", bus.pf_reg_write_data[0], 32'd0);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    #1;
    check("drain_wb_valid", {30'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hBAD0_BAD0;
    #1;
    check("drain_dok_pause_mem", {31'd0, pause_mem}, 32'd1);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    #1;
    check("drain_dok_wb_data0", bus.wb_reg_write_data[0], 32'd0);
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    check("post_drain_pause_mem", {31'd0, pause_mem}, 32'd0);
    @(posedge clk);
    #1;
    check("post_drain_wb_data0", bus.wb_reg_write_data[0], 32'h55);
    check("drain_stall_cnt", stall_cnt, exp_stall);

    // ALU result forwarded next to a pending load in the other lane
    @(negedge clk);
    drive(2'b11, 2'b10, 3'd2, 2'd0, 32'h7, 32'h0);
    #1;
    check("fwd_pause_mem", {31'd0, pause_mem}, 32'd1);
    check("fwd_load_busy", {31'd0, load_busy}, 32'd1);
    check("fwd_pf_en", {30'd0, bus.pf_reg_write_en}, 32'd1);
    check("fwd_pf_addr0", {27'd0, bus.pf_reg_write_addr[0]}, 32'd5);
    check("fwd_pf_data0", bus.pf_reg_write_data[0], 32'd7);
    @(posedge clk);
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'h0000_0011;
    @(posedge clk);
    #1;
    check("fwd_wb_data0", bus.wb_reg_write_data[0], 32'd7);
    check("fwd_wb_data1", bus.wb_reg_write_data[1], 32'h11);
    check("fwd_wb_addr1", {27'd0, bus.wb_reg_write_addr[1]}, 32'd6);
    check("fwd_stall_cnt", stall_cnt, exp_stall);

    // Reset during WAIT
    @(negedge clk);
    data_ok = 1'b0;
    drive(2'b01, 2'b01, 3'd2, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("wrst_wb_valid", {30'd0, bus.wb_valid}, 32'd0);
    check("wrst_wb_data0", bus.wb_reg_write_data[0], 32'd0);
    check("wrst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("wrst_pause_mem", {31'd0, pause_mem}, 32'd0);
    check("wrst_load_busy", {31'd0, load_busy}, 32'd0);

    // Stray data_ok in IDLE with no load is ignored
    data_ok = 1'b1; rdata = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    data_ok = 1'b0;
    drive(2'b01, 2'b00, 3'd0, 2'd0, 32'h42, 32'h0);
    #1;
    check("stray_pause_mem", {31'd0, pause_mem}, 32'd0);
    @(posedge clk);
    #1;
    check("stray_wb_data0", bus.wb_reg_write_data[0], 32'h42);
    check("stray_stall_cnt", stall_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
